wptr_full_ctrl: RTL and testbench

//  Write-side pointer and full-flag controller for the dual-clock (async) FIFO.

---
 rtl/wptr_full_ctrl.sv | 77 +++++++
 tb/tb_wptr_full_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/full controller for a dual-clock FIFO (wclk domain).
// Binary write counter, Gray write pointer, full / almost-full / level / sticky overflow.
module wptr_full_ctrl #(
  parameter int unsigned ASIZE        = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam logic [ASIZE:0] AFULL_LVL = AFULL_THRESH[ASIZE:0];

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wptr_q, wgray_d;
  logic [ASIZE:0] wlevel_q, level_d;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] rptr_full_cmp;
  logic           wfull_q, wfull_d;
  logic           afull_q, afull_d;
  logic           wovf_q, wovf_d;
  logic           wr_accept;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of bits ASIZE..i.
  genvar gi;
  generate
    for (gi = 0; gi <= ASIZE; gi++) begin : g_rgray2bin
      assign rbin_s[gi] = ^wq2_rptr[ASIZE:gi];
    end
  endgenerate

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign rptr_full_cmp = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};

  always_comb begin
    wr_accept = winc & ~wfull_q;
    wbin_d    = wbin_q + {{ASIZE{1'b0}}, wr_accept};
    wgray_d   = (wbin_d >> 1) ^ wbin_d;
    level_d   = wbin_d - rbin_s;
    wfull_d   = (wgray_d == rptr_full_cmp);
    afull_d   = (level_d >= AFULL_LVL);
    wovf_d    = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= level_d;
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ASIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed phases plus a randomized
// write/read run, checked against a count-based FIFO occupancy model.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  wptr_full_ctrl #(.ASIZE(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  int tests = 0;
  int fails = 0;

  // Model: counts of words written and read (mod 32), occupancy derived from them.
  int   m_w = 0;
  int   m_r = 0;
  int   m_level = 0;
  bit   m_full = 0;
  bit   m_af = 0;
  bit   m_ovf = 0;
  bit   m_valid = 0;
  int   accepted = 0;
  logic [4:0] prev_wptr = '0;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One wclk cycle: drive inputs, check waddr before the edge, then check registered outputs.
  task automatic step(input bit rst, input bit inc, input int rcount);
    bit acc;
    @(negedge wclk);
    wrst     = rst;
    winc     = inc;
    m_r      = rcount % 32;
    wq2_rptr = gray(m_r);
    #1;
    if (m_valid) check("waddr", {28'd0, waddr}, m_w % 16);
    @(posedge wclk);
    #1;
    if (rst) begin
      m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
      m_valid = 1;
    end else begin
      acc      = inc && !m_full;
      m_ovf    = m_ovf || (inc && m_full);
      m_w      = (m_w + (acc ? 1 : 0)) % 32;
      m_level  = (m_w - m_r + 32) % 32;
      m_full   = (m_level == 16);
      m_af     = (m_level >= 12);
      accepted += acc ? 1 : 0;
      tests++;
      assert ($countones(wptr ^ prev_wptr) <= 1) else begin
        fails++;
        $error("FAIL gray_delta: observed %0h prev %0h required <=1 bit change", wptr, prev_wptr);
      end
    end
    check("wptr",         {27'd0, wptr},         gray(m_w));
    check("wfull",        {31'd0, wfull},        m_full);
    check("walmost_full", {31'd0, walmost_full}, m_af);
    check("wlevel",       {27'd0, wlevel},       m_level);
    check("woverflow",    {31'd0, woverflow},    m_ovf);
    prev_wptr = wptr;
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;

    // Reset held two cycles with winc high: nothing may be written.
    step(1, 1, 0);
    step(1, 1, 0);
    check("rst_waddr", {28'd0, waddr}, 0);

    // Fill 16 words with the reader idle.
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    check("fill_wptr", {27'd0, wptr}, 5'b11000);
    check("fill_full", {31'd0, wfull}, 1);

    // Writes while full are refused and flagged stickily.
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("ovf_sticky", {31'd0, woverflow}, 1);

    // One read frees a slot; the next write wraps to address 0 and refills.
    step(0, 0, 1);
    check("drain_level", {27'd0, wlevel}, 15);
    step(0, 1, 1);
    check("refill_full", {31'd0, wfull}, 1);

    // Level 8, then write and read together every cycle across the 31->0 wrap.
    step(0, 0, 9);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 9 + i);
      check("simul_level", {27'd0, wlevel}, 8);
    end

    // Randomized traffic until 64 writes are accepted; the reader never overtakes.
    accepted = 0;
    for (int c = 0; c < 1000 && accepted < 64; c++) begin
      int nr;
      nr = m_r;
      if (m_level != 0 && $urandom_range(0, 1) == 1) nr = m_r + 1;
      step(0, ($urandom_range(0, 3) != 0), nr);
    end
    check("rand_accepted", {31'd0, (accepted >= 64)}, 1);

    // Only reset clears the overflow flag.
    step(1, 0, 0);
    check("final_ovf", {31'd0, woverflow}, 0);
    step(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
